// File: rtl/lut_multiplier_32b_seq_ctrl.sv
// Sequential 32x32 unsigned multiplier: one 32x4 nibble product per RUN cycle,
// shift-accumulated into a 64-bit result, with valid/ready on both sides.
module lut_multiplier_32b_seq_ctrl #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk_32b,
    input  logic        resetn_32b,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] source_number_32b_0,
    input  logic [31:0] source_number_32b_1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result_64b,
    output logic        busy,
    output logic [2:0]  nib_idx
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] acc_q;
    logic [63:0] result_q;
    logic [2:0]  nib_q;

    logic [3:0]  nibble;
    logic [35:0] partial;
    logic [63:0] acc_next;
    logic [5:0]  rest_shift;
    logic        last_step;

    always_comb begin
        nibble     = b_q[{nib_q, 2'b00} +: 4];
        partial    = {4'b0, a_q} * {32'b0, nibble};
        acc_next   = acc_q + ({28'b0, partial} << {nib_q, 2'b00});
        rest_shift = {1'b0, nib_q, 2'b00} + 6'd4;
        // Nibble 7 always ends the run; otherwise exit early once no nonzero nibble remains.
        last_step  = (nib_q == 3'd7) ||
                     (SKIP_ZERO && ((b_q >> rest_shift) == 32'b0));
    end

    always_ff @(posedge clk_32b) begin
        if (!resetn_32b) begin
            state_q  <= IDLE;
            a_q      <= 32'b0;
            b_q      <= 32'b0;
            acc_q    <= 64'b0;
            result_q <= 64'b0;
            nib_q    <= 3'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= source_number_32b_0;
                        b_q     <= source_number_32b_1;
                        acc_q   <= 64'b0;
                        nib_q   <= 3'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_next;
                    nib_q <= nib_q + 3'd1;
                    if (last_step) begin
                        result_q <= acc_next;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Result lives in its own register so it survives the next accept clearing acc.
    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == RUN) || (state_q == DONE);
    assign result_64b = result_q;
    assign nib_idx    = nib_q;

endmodule

// File: tb/tb_lut_multiplier_32b_seq_ctrl.sv
// Directed bench: one instance with SKIP_ZERO=0 (index 0) and one with SKIP_ZERO=1 (index 1).
module tb_lut_multiplier_32b_seq_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] src_a = 32'b0;
    logic [31:0] src_b = 32'b0;
    logic [1:0]  in_valid = 2'b0;
    logic [1:0]  out_ready = 2'b0;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  busy;
    logic [63:0] res [2];
    logic [2:0]  nib [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lut_multiplier_32b_seq_ctrl #(.SKIP_ZERO(1'b0)) u_dut0 (
        .clk_32b(clk), .resetn_32b(resetn), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .source_number_32b_0(src_a), .source_number_32b_1(src_b),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result_64b(res[0]),
        .busy(busy[0]), .nib_idx(nib[0])
    );

    lut_multiplier_32b_seq_ctrl #(.SKIP_ZERO(1'b1)) u_dut1 (
        .clk_32b(clk), .resetn_32b(resetn), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .source_number_32b_0(src_a), .source_number_32b_1(src_b),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result_64b(res[1]),
        .busy(busy[1]), .nib_idx(nib[1])
    );

    typedef struct {
        int          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid on instance d; returns edges counted since accept (bounded).
    task automatic wait_done(input int d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic deliver(input int d, input string name);
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        check({name, " out_valid low after handshake"}, 64'(out_valid[d]), 64'd0);
        check({name, " in_ready after handshake"}, 64'(in_ready[d]), 64'd1);
    endtask

    task automatic run_mul(input int d, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_res, input int exp_lat, input string name);
        int lat;
        src_a = a;
        src_b = b;
        in_valid[d] = 1'b1;
        check({name, " in_ready before accept"}, 64'(in_ready[d]), 64'd1);
        tick();
        in_valid[d] = 1'b0;
        wait_done(d, lat);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, res[d], exp_res);
        deliver(d, name);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 8};
        vecs[1]  = '{1, 32'h12345678, 32'h00000005, 64'h000000005B05B058, 1};
        vecs[2]  = '{1, 32'h00000003, 32'h10000000, 64'h0000000030000000, 8};
        vecs[3]  = '{0, 32'h00000000, 32'hFFFFFFFF, 64'h0, 8};
        vecs[4]  = '{0, 32'hFFFFFFFF, 32'h00000000, 64'h0, 8};
        vecs[5]  = '{1, 32'h00000000, 32'hFFFFFFFF, 64'h0, 8};
        vecs[6]  = '{1, 32'hFFFFFFFF, 32'h00000000, 64'h0, 1};
        vecs[7]  = '{1, 32'h00000010, 32'h00000100, 64'h0000000000001000, 3};
        vecs[8]  = '{1, 32'hFFFFFFFF, 32'h00000010, 64'h0000000FFFFFFFF0, 2};
        vecs[9]  = '{0, 32'h00000007, 32'h00000006, 64'h000000000000002A, 8};
        vecs[10] = '{1, 32'h12345678, 32'h12345678, 64'h014B66DC1DF4D840, 8};
        vecs[11] = '{1, 32'h00000002, 32'h00FFFFFF, 64'h0000000001FFFFFE, 6};

        // Reset held for two edges with in_valid asserted.
        in_valid = 2'b11;
        src_a = 32'h1111_1111;
        src_b = 32'h2222_2222;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check("reset in_ready", 64'(in_ready[d]), 64'd1);
            check("reset out_valid", 64'(out_valid[d]), 64'd0);
            check("reset busy", 64'(busy[d]), 64'd0);
            check("reset result", res[d], 64'd0);
            check("reset nib_idx", 64'(nib[d]), 64'd0);
        end
        in_valid = 2'b00;
        resetn = 1'b1;
        tick();
        check("post-reset idle busy0", 64'(busy[0]), 64'd0);
        check("post-reset idle busy1", 64'(busy[1]), 64'd0);

        // Full-length run with nibble index trace.
        src_a = 32'hFFFFFFFF;
        src_b = 32'hFFFFFFFF;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("trace nib_idx", 64'(nib[0]), 64'(i));
            check("trace busy", 64'(busy[0]), 64'd1);
            check("trace in_ready", 64'(in_ready[0]), 64'd0);
            check("trace out_valid", 64'(out_valid[0]), 64'd0);
            tick();
        end
        check("trace done out_valid", 64'(out_valid[0]), 64'd1);
        check("trace result", res[0], 64'hFFFFFFFE00000001);
        deliver(0, "trace");

        for (int i = 0; i < 12; i++) begin
            run_mul(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat,
                    $sformatf("vec%0d", i));
        end

        // Backpressure with a new operand pair offered while DONE.
        src_a = 32'h10;
        src_b = 32'h100;
        in_valid[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        wait_done(1, lat);
        check("bp latency", 64'(lat), 64'd3);
        src_a = 32'h5;
        src_b = 32'h9;
        in_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp out_valid stable", 64'(out_valid[1]), 64'd1);
            check("bp result stable", res[1], 64'h1000);
            check("bp in_ready low", 64'(in_ready[1]), 64'd0);
        end
        out_ready[1] = 1'b1;
        tick();
        out_ready[1] = 1'b0;
        check("bp in_ready after deliver", 64'(in_ready[1]), 64'd1);
        check("bp busy after deliver", 64'(busy[1]), 64'd0);
        check("bp result held", res[1], 64'h1000);
        tick();
        in_valid[1] = 1'b0;
        check("bp second accepted", 64'(busy[1]), 64'd1);
        wait_done(1, lat);
        check("bp second latency", 64'(lat), 64'd1);
        check("bp second result", res[1], 64'h2D);
        deliver(1, "bp");

        // Reset in the middle of a run.
        src_a = 32'hDEADBEEF;
        src_b = 32'hCAFEBABE;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        lat = 0;
        while (nib[0] != 3'd3 && lat < 20) begin
            tick();
            lat++;
        end
        check("abort reached nib 3", 64'(nib[0]), 64'd3);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("abort in_ready", 64'(in_ready[0]), 64'd1);
        check("abort busy", 64'(busy[0]), 64'd0);
        check("abort result", res[0], 64'd0);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid[0]) lat++;
        end
        check("abort out_valid never", 64'(lat), 64'd0);
        run_mul(1, 32'd7, 32'd6, 64'h2A, 1, "after abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
